// File: rtl/block_dispatch_scheduler.sv
// Tiled matrix-multiply scheduler: hands C-block (row, col) pairs to free tiles,
// counts tile completions, and round-robin arbitrates the shared memory port.
//
// top state | meaning
// ----------+-----------------------------------------------
// idle      | waiting for in_start
// dispatch  | offering one block per cycle to the lowest free slot
// drain     | all blocks handed out, waiting for the remaining results
// done      | one-cycle completion pulse, then back to idle
//
// slot state | meaning
// -----------+----------------------------------------------
// free       | tile idle, may be assigned a block
// offer      | index_ready asserted, waiting for index_ack
// work       | tile computing, waiting for result_ready
module block_dispatch_scheduler #(
  parameter int num_proc    = 4,
  parameter int index_width = 8,
  parameter int count_width = 2*index_width
) (
  input  logic                            in_clk,
  input  logic                            in_reset,
  input  logic                            in_start,
  input  logic [index_width-1:0]          in_row_blocks,
  input  logic [index_width-1:0]          in_col_blocks,
  input  logic [index_width-1:0]          in_mu,
  output logic [index_width-1:0]          out_mu,
  output logic [num_proc*index_width-1:0] out_row_index,
  output logic [num_proc*index_width-1:0] out_col_index,
  output logic [num_proc-1:0]             out_index_ready,
  input  logic [num_proc-1:0]             in_index_ack,
  input  logic [num_proc-1:0]             in_result_ready,
  input  logic [num_proc-1:0]             in_request,
  output logic [num_proc-1:0]             out_grant,
  output logic                            out_busy,
  output logic                            out_done
);
  localparam int ptr_w = (num_proc > 1) ? $clog2(num_proc) : 1;

  localparam logic [1:0] st_idle     = 2'd0;
  localparam logic [1:0] st_dispatch = 2'd1;
  localparam logic [1:0] st_drain    = 2'd2;
  localparam logic [1:0] st_done     = 2'd3;

  localparam logic [1:0] slot_free  = 2'd0;
  localparam logic [1:0] slot_offer = 2'd1;
  localparam logic [1:0] slot_work  = 2'd2;

  logic [1:0]             state;
  logic [index_width-1:0] rows_q, cols_q, mu_q, next_row, next_col;
  logic [count_width-1:0] total_q, assigned, completed, finish_cnt;
  logic [1:0]             slot_state [num_proc];
  logic [index_width-1:0] row_idx [num_proc];
  logic [index_width-1:0] col_idx [num_proc];
  logic                   free_found, assign_en;
  logic [ptr_w-1:0]       free_sel;

  logic [num_proc-1:0]    grant_q;
  logic [ptr_w-1:0]       ptr, holder, scan_sel, ptr_next;
  logic                   scan_found;
  logic [2*num_proc-1:0]  req_rot;

  always_comb begin
    free_found = 1'b0;
    free_sel   = '0;
    finish_cnt = '0;
    for (int p = num_proc-1; p >= 0; p--) begin
      if (slot_state[p] == slot_free) begin
        free_found = 1'b1;
        free_sel   = ptr_w'(p);
      end
    end
    for (int p = 0; p < num_proc; p++) begin
      if (slot_state[p] == slot_work && in_result_ready[p])
        finish_cnt = finish_cnt + count_width'(1);
    end
  end

  assign assign_en = (state == st_dispatch) && free_found;

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state     <= st_idle;
      rows_q    <= '0;
      cols_q    <= '0;
      mu_q      <= '0;
      total_q   <= '0;
      next_row  <= '0;
      next_col  <= '0;
      assigned  <= '0;
      completed <= '0;
      for (int p = 0; p < num_proc; p++) begin
        slot_state[p] <= slot_free;
        row_idx[p]    <= '0;
        col_idx[p]    <= '0;
      end
    end else begin
      completed <= completed + finish_cnt;
      for (int p = 0; p < num_proc; p++) begin
        case (slot_state[p])
          slot_free: if (assign_en && free_sel == ptr_w'(p)) begin
            slot_state[p] <= slot_offer;
            row_idx[p]    <= next_row;
            col_idx[p]    <= next_col;
          end
          slot_offer: if (in_index_ack[p]) slot_state[p] <= slot_work;
          slot_work:  if (in_result_ready[p]) slot_state[p] <= slot_free;
          default:    slot_state[p] <= slot_free;
        endcase
      end
      case (state)
        st_idle: if (in_start) begin
          rows_q    <= in_row_blocks;
          cols_q    <= in_col_blocks;
          mu_q      <= in_mu;
          total_q   <= count_width'(in_row_blocks) * count_width'(in_col_blocks);
          next_row  <= '0;
          next_col  <= '0;
          assigned  <= '0;
          completed <= '0;
          state     <= (in_row_blocks == '0 || in_col_blocks == '0) ? st_done : st_dispatch;
        end
        st_dispatch: if (assign_en) begin
          assigned <= assigned + count_width'(1);
          if (next_col == cols_q - index_width'(1)) begin
            next_col <= '0;
            next_row <= next_row + index_width'(1);
          end else begin
            next_col <= next_col + index_width'(1);
          end
          if (assigned + count_width'(1) == total_q) state <= st_drain;
        end
        st_drain: if (completed == total_q) state <= st_done;
        st_done:  state <= st_idle;
        default:  state <= st_idle;
      endcase
    end
  end

  always_comb begin
    out_index_ready = '0;
    out_row_index   = '0;
    out_col_index   = '0;
    for (int p = 0; p < num_proc; p++) begin
      out_index_ready[p] = (slot_state[p] == slot_offer);
      out_row_index[p*index_width +: index_width] = row_idx[p];
      out_col_index[p*index_width +: index_width] = col_idx[p];
    end
  end

  assign out_mu   = mu_q;
  assign out_busy = (state == st_dispatch) || (state == st_drain);
  assign out_done = (state == st_done);

  // Request vector doubled so a shift by the pointer gives a rotated view.
  always_comb begin
    int sel_i;
    int hn;
    req_rot    = {in_request, in_request} >> ptr;
    scan_found = 1'b0;
    scan_sel   = '0;
    holder     = '0;
    sel_i      = 0;
    for (int k = num_proc-1; k >= 0; k--) begin
      if (req_rot[k]) begin
        scan_found = 1'b1;
        sel_i      = int'(ptr) + k;
        if (sel_i >= num_proc) sel_i = sel_i - num_proc;
        scan_sel   = ptr_w'(sel_i);
      end
    end
    for (int p = 0; p < num_proc; p++) begin
      if (grant_q[p]) holder = ptr_w'(p);
    end
    hn = int'(holder) + 1;
    if (hn >= num_proc) hn = 0;
    ptr_next = ptr_w'(hn);
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      grant_q <= '0;
      ptr     <= '0;
    end else if (grant_q != '0) begin
      if ((grant_q & in_request) == '0) begin
        grant_q <= '0;
        ptr     <= ptr_next;
      end
    end else if (scan_found) begin
      grant_q <= num_proc'(1) << scan_sel;
    end
  end

  assign out_grant = grant_q;

endmodule

// File: tb/tb_block_dispatch_scheduler.sv
// Self-checking bench for block_dispatch_scheduler: tile responder model with an
// offer scoreboard, a memory-request model with a grant-order scoreboard.
module tb_block_dispatch_scheduler;
  localparam int NP = 4;
  localparam int IW = 8;

  logic             in_clk = 1'b0;
  logic             in_reset = 1'b0;
  logic             in_start = 1'b0;
  logic [IW-1:0]    in_row_blocks = '0;
  logic [IW-1:0]    in_col_blocks = '0;
  logic [IW-1:0]    in_mu = '0;
  logic [NP-1:0]    in_index_ack = '0;
  logic [NP-1:0]    in_result_ready = '0;
  logic [NP-1:0]    in_request = '0;
  logic [IW-1:0]    out_mu;
  logic [NP*IW-1:0] out_row_index;
  logic [NP*IW-1:0] out_col_index;
  logic [NP-1:0]    out_index_ready;
  logic [NP-1:0]    out_grant;
  logic             out_busy;
  logic             out_done;

  typedef struct {int tile; int row; int col;} offer_t;

  offer_t exp_q[$];
  int grant_exp_q[$];
  int off_cyc[$];
  int grant_on[$];
  int ts[NP];
  int cd[NP];
  int hold_r[NP];
  int hold_c[NP];
  int ack_dly[NP];
  int req_hold[NP];
  int gcnt[NP];
  int res_dly = 10;
  int cyc = 0;
  int done_cnt = 0;
  int results_sent = 0;
  int cur_blocks = 0;
  int total = 0;
  int bad = 0;
  bit ready_seen = 1'b0;
  logic [NP-1:0] prev_grant = '0;

  block_dispatch_scheduler #(.num_proc(NP), .index_width(IW), .count_width(2*IW)) dut (
    .in_clk(in_clk),
    .in_reset(in_reset),
    .in_start(in_start),
    .in_row_blocks(in_row_blocks),
    .in_col_blocks(in_col_blocks),
    .in_mu(in_mu),
    .out_mu(out_mu),
    .out_row_index(out_row_index),
    .out_col_index(out_col_index),
    .out_index_ready(out_index_ready),
    .in_index_ack(in_index_ack),
    .in_result_ready(in_result_ready),
    .in_request(in_request),
    .out_grant(out_grant),
    .out_busy(out_busy),
    .out_done(out_done)
  );

  always #5 in_clk = ~in_clk;

  // One cycle: sample at the falling edge, run tile and requester models, drive next inputs.
  task automatic tick();
    offer_t e;
    int r, c, g, eg;
    @(negedge in_clk);
    cyc++;
    if (out_done === 1'b1) begin
      done_cnt++;
      total++;
      if (out_busy !== 1'b0 || results_sent != cur_blocks) begin
        bad++;
        $display("FAIL done_state busy=%0b results=%0d expected busy=0 results=%0d", out_busy, results_sent, cur_blocks);
      end
    end
    if (out_index_ready !== '0) ready_seen = 1'b1;
    for (int p = 0; p < NP; p++) begin
      r = int'(out_row_index[p*IW +: IW]);
      c = int'(out_col_index[p*IW +: IW]);
      case (ts[p])
        0: if (out_index_ready[p] === 1'b1) begin
          off_cyc.push_back(cyc);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL offer_unexpected tile=%0d row=%0d col=%0d expected none", p, r, c);
          end else begin
            e = exp_q.pop_front();
            if (e.tile != p || e.row != r || e.col != c) begin
              bad++;
              $display("FAIL offer got tile=%0d row=%0d col=%0d expected tile=%0d row=%0d col=%0d", p, r, c, e.tile, e.row, e.col);
            end
          end
          hold_r[p] = r;
          hold_c[p] = c;
          cd[p] = ack_dly[p];
          ts[p] = 1;
        end
        1: begin
          total++;
          if (out_index_ready[p] !== 1'b1 || r != hold_r[p] || c != hold_c[p]) begin
            bad++;
            $display("FAIL offer_hold tile=%0d ready=%0b row=%0d col=%0d expected ready=1 row=%0d col=%0d", p, out_index_ready[p], r, c, hold_r[p], hold_c[p]);
          end
          if (cd[p] > 0) cd[p]--;
          if (cd[p] == 0) begin
            in_index_ack[p] = 1'b1;
            ts[p] = 2;
          end
        end
        2: begin
          in_index_ack[p] = 1'b0;
          total++;
          if (out_index_ready[p] !== 1'b0) begin
            bad++;
            $display("FAIL ready_drop tile=%0d ready=%0b expected 0", p, out_index_ready[p]);
          end
          cd[p] = res_dly;
          ts[p] = 3;
        end
        3: begin
          cd[p]--;
          if (cd[p] == 0) begin
            in_result_ready[p] = 1'b1;
            results_sent++;
            ts[p] = 4;
          end
        end
        default: begin
          in_result_ready[p] = 1'b0;
          ts[p] = 0;
        end
      endcase
    end
    if (out_grant !== '0) begin
      total++;
      if ($countones(out_grant) != 1) begin
        bad++;
        $display("FAIL grant_onehot got=%b expected one bit", out_grant);
      end
    end
    if (out_grant !== '0 && prev_grant === '0) begin
      g = -1;
      for (int p = NP-1; p >= 0; p--) if (out_grant[p] === 1'b1) g = p;
      grant_on.push_back(cyc);
      total++;
      if (grant_exp_q.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected got=%0d expected none", g);
      end else begin
        eg = grant_exp_q.pop_front();
        if (g != eg) begin
          bad++;
          $display("FAIL grant_order got=%0d expected=%0d", g, eg);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (out_grant[p] === 1'b1) begin
        gcnt[p]++;
        if (gcnt[p] >= req_hold[p]) begin
          in_request[p] = 1'b0;
          gcnt[p] = 0;
        end
      end
    end
    prev_grant = out_grant;
  endtask

  task automatic reset_tb();
    for (int p = 0; p < NP; p++) begin
      ts[p] = 0;
      cd[p] = 0;
      gcnt[p] = 0;
      ack_dly[p] = 1;
      req_hold[p] = 4;
    end
    in_index_ack = '0;
    in_result_ready = '0;
    in_request = '0;
    exp_q.delete();
    grant_exp_q.delete();
    off_cyc.delete();
    grant_on.delete();
    prev_grant = '0;
  endtask

  task automatic push_offer(input int t, input int r, input int c);
    offer_t e;
    e.tile = t;
    e.row = r;
    e.col = c;
    exp_q.push_back(e);
  endtask

  task automatic start_job(input int r, input int c, input int m);
    in_row_blocks = IW'(r);
    in_col_blocks = IW'(c);
    in_mu = IW'(m);
    cur_blocks = r * c;
    results_sent = 0;
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL done_timeout cycles=%0d expected done pulse", n);
    end
  endtask

  task automatic check_after_job(input string name);
    int d0 = done_cnt;
    repeat (3) tick();
    total++;
    if (done_cnt != d0 || out_busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_tail extra_done=%0d busy=%0b left=%0d expected 0 0 0", name, done_cnt - d0, out_busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_tb();
    in_reset = 1'b0;
    tick();
    tick();
    total++;
    if ({out_mu, out_row_index, out_col_index, out_index_ready, out_grant, out_busy, out_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs busy=%0b done=%0b ready=%b grant=%b mu=%0d expected all 0", out_busy, out_done, out_index_ready, out_grant, out_mu);
    end
    in_reset = 1'b1;
    tick();
    total++;
    if (out_busy !== 1'b0 || out_index_ready !== '0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%0b ready=%b expected 0 0", out_busy, out_index_ready);
    end
  endtask

  task automatic test_basic();
    reset_tb();
    push_offer(0, 0, 0);
    push_offer(1, 0, 1);
    push_offer(2, 1, 0);
    push_offer(3, 1, 1);
    start_job(2, 2, 3);
    total++;
    if (out_busy !== 1'b1 || out_mu !== IW'(3)) begin
      bad++;
      $display("FAIL basic_start busy=%0b mu=%0d expected 1 3", out_busy, out_mu);
    end
    wait_done(200);
    total++;
    if (off_cyc.size() != 4 || off_cyc[1] - off_cyc[0] != 1 || off_cyc[2] - off_cyc[0] != 2 || off_cyc[3] - off_cyc[0] != 3) begin
      bad++;
      $display("FAIL basic_consecutive offers=%0d expected 4 on consecutive cycles", off_cyc.size());
    end
    check_after_job("basic");
  endtask

  task automatic test_refill();
    reset_tb();
    push_offer(0, 0, 0);
    push_offer(1, 0, 1);
    push_offer(2, 1, 0);
    push_offer(3, 1, 1);
    push_offer(0, 2, 0);
    push_offer(1, 2, 1);
    start_job(3, 2, 1);
    wait_done(300);
    total++;
    if (off_cyc.size() != 6 || off_cyc[4] - off_cyc[0] != res_dly + 4 || off_cyc[5] - off_cyc[0] != res_dly + 5) begin
      bad++;
      $display("FAIL refill_timing offers=%0d d4=%0d d5=%0d expected 6 %0d %0d", off_cyc.size(),
               (off_cyc.size() > 4) ? off_cyc[4] - off_cyc[0] : -1, (off_cyc.size() > 5) ? off_cyc[5] - off_cyc[0] : -1, res_dly + 4, res_dly + 5);
    end
    check_after_job("refill");
  endtask

  task automatic test_slow_ack();
    reset_tb();
    ack_dly[1] = 5;
    push_offer(0, 0, 0);
    push_offer(1, 0, 1);
    push_offer(2, 1, 0);
    push_offer(3, 1, 1);
    start_job(2, 2, 7);
    wait_done(200);
    total++;
    if (off_cyc.size() != 4 || off_cyc[3] - off_cyc[0] != 3) begin
      bad++;
      $display("FAIL slow_ack_others offers=%0d expected 4 consecutive", off_cyc.size());
    end
    check_after_job("slow_ack");
  endtask

  task automatic test_empty();
    int d0;
    reset_tb();
    ready_seen = 1'b0;
    d0 = done_cnt;
    start_job(0, 3, 2);
    tick();
    total++;
    if (done_cnt != d0 + 1 || ready_seen) begin
      bad++;
      $display("FAIL empty_job dones=%0d ready_seen=%0b expected 1 0", done_cnt - d0, ready_seen);
    end
  endtask

  task automatic test_arbiter();
    int t0;
    reset_tb();
    grant_exp_q.push_back(0);
    grant_exp_q.push_back(2);
    grant_exp_q.push_back(3);
    t0 = cyc;
    in_request = 4'b1101;
    repeat (17) tick();
    total++;
    if (grant_on.size() != 3 || grant_on[0] != t0 + 1 || grant_on[1] - grant_on[0] != 5 || grant_on[2] - grant_on[1] != 5) begin
      bad++;
      $display("FAIL arb_timing grants=%0d first=%0d expected 3 grants at +1, +6, +11", grant_on.size(),
               (grant_on.size() > 0) ? grant_on[0] - t0 : -1);
    end
    grant_exp_q.push_back(1);
    grant_exp_q.push_back(0);
    in_request[1] = 1'b1;
    tick();
    in_request[0] = 1'b1;
    repeat (14) tick();
    total++;
    if (grant_on.size() != 5 || grant_exp_q.size() != 0 || out_grant !== '0) begin
      bad++;
      $display("FAIL arb_rerequest grants=%0d pending=%0d grant=%b expected 5 0 0", grant_on.size(), grant_exp_q.size(), out_grant);
    end
  endtask

  task automatic test_reset_mid();
    reset_tb();
    push_offer(0, 0, 0);
    push_offer(1, 0, 1);
    push_offer(2, 0, 2);
    push_offer(3, 0, 3);
    grant_exp_q.push_back(2);
    req_hold[2] = 100;
    in_request[2] = 1'b1;
    start_job(4, 4, 5);
    repeat (5) tick();
    total++;
    if (out_busy !== 1'b1 || out_grant !== 4'b0100) begin
      bad++;
      $display("FAIL midreset_pre busy=%0b grant=%b expected 1 0100", out_busy, out_grant);
    end
    #1 in_reset = 1'b0;
    #1;
    total++;
    if ({out_mu, out_row_index, out_col_index, out_index_ready, out_grant, out_busy, out_done} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs busy=%0b ready=%b grant=%b mu=%0d expected all 0", out_busy, out_index_ready, out_grant, out_mu);
    end
    reset_tb();
    tick();
    tick();
    in_reset = 1'b1;
    tick();
    push_offer(0, 0, 0);
    start_job(1, 1, 2);
    wait_done(100);
    check_after_job("restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_refill();
    test_slow_ack();
    test_empty();
    test_arbiter();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
